gcd_stein: RTL and testbench
============================

// Module: gcd_stein
//
// PURPOSE
//   Parametrised successor to the existing gcd unit: computes the greatest common
//   divisor of two WIDTH-bit unsigned operands with the binary (Stein) algorithm.
//   Subtraction is used only on odd operands; no divider is needed.
//   Adds a ready flag, single-cycle zero-operand handling and an error flag.
//   Same start/done handshake as the existing unit, so the gcd testbench drives it
//   with only a port-map change.
//
// PARAMETERS
//   WIDTH   32   operand/result width in bits (>=2)
//   KW      $clog2(WIDTH)+1   width of common-power-of-two shift counter k
//
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high reset
//   start    in   1      request; sampled only while ready=1
//   a_in     in   WIDTH  operand A, sampled with accepted start
//   b_in     in   WIDTH  operand B, sampled with accepted start
//   ready    out  1      1 in IDLE: a start will be accepted this cycle
//   done     out  1      one-cycle pulse: result/err valid
//   result   out  WIDTH  gcd(a_in,b_in); held from done until the next accepted start
//   err      out  1      1 with done when both operands are 0; held like result
//
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, ready=1, done=0, result=0, err=0, a=b=k=0.
//   - Accept: posedge with state==IDLE && start==1. Latch a<=a_in, b<=b_in, k<=0; clear err.
//     Start in any other state is ignored, with no queuing.
//   - States and transitions (one step per clock):
//     IDLE   : accept & a_in==0 & b_in==0 -> DONE, result<=0, err<=1
//              accept & a_in==0 -> DONE, result<=b_in
//              accept & b_in==0 -> DONE, result<=a_in
//              accept, otherwise -> COMMON
//     COMMON : a,b both even -> a>>=1, b>>=1, k++; else -> ODDA
//     ODDA   : a even -> a>>=1; else -> REDUCE
//     REDUCE : b==0 -> result<=a<<k, go DONE
//              b even -> b>>=1
//              b odd & a>b -> a<=b, b<=a-b
//              b odd & a<=b -> b<=b-a
//     DONE   : done=1 for exactly this cycle -> IDLE
//   - Invariant in REDUCE: a is odd and nonzero.
//     Subtractions never underflow and stay within WIDTH bits.
//     a<<k never exceeds the max operand, so there is no overflow.
//   - Latency (accepted edge to done-high cycle):
//     zero operand: done high in the cycle after the accepting edge.
//     general case: <= 4*WIDTH+4 cycles.
//   - ready=0 from the cycle after accept through the DONE cycle.
//     ready=1 again in the cycle after done, so back-to-back trials are spaced by 1 IDLE cycle.
//   - result/err update only on entry to DONE; unchanged during computation.
//   - Reset mid-operation: computation is abandoned and result/err cleared; no done pulse.
//   - a_in/b_in changing after acceptance has no effect.
//
// TESTING
//   1. WIDTH=32, a=48 b=36 -> done pulse 1 cycle, result=12, err=0, ready back high next cycle
//   2. a=17 b=13 (coprime, odd) -> result=1; a=32'hFFFFFFFF b=1 -> result=1 within 132 cycles
//   3. a=0 b=25 -> result=25 with done 1 cycle after accept; a=0 b=0 -> result=0, err=1
//   4. start held high and a_in/b_in toggled while busy on 12,18 -> single done, result=6
//   5. reset pulsed mid-computation of 1024,768 -> ready=1, done=0, result=0;
//      next start 1024,768 -> result=256
//   6. WIDTH=8: 255,85 -> 85; 128,64 -> 64 (k path); random pairs vs reference model,
//      latency <= 36 cycles

Source files
------------

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD of two WIDTH-bit unsigned operands with a start/done handshake.
// Uses shifts and odd-operand subtraction only, with a fast path for zero operands.
module gcd_stein #(
  parameter int WIDTH = 32,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       dbg_state
);

  // Handshake: start is taken only on a clock edge where ready=1 (IDLE); a_in/b_in
  // are captured on that edge. done pulses for one cycle when result/err become
  // valid, and both hold until the next accepted start. No request is ever queued.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COMMON = 3'd1,
    S_ODDA   = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a_in;
          b_d   = b_in;
          k_d   = '0;
          err_d = 1'b0;
          if (a_in == '0 && b_in == '0) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end else if (a_in == '0) begin
            result_d = b_in;
            state_d  = S_DONE;
          end else if (b_in == '0) begin
            result_d = a_in;
            state_d  = S_DONE;
          end else begin
            state_d = S_COMMON;
          end
        end
      end
      S_COMMON: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = S_ODDA;
        end
      end
      S_ODDA: begin
        if (!a_q[0]) a_d = a_q >> 1;
        else         state_d = S_REDUCE;
      end
      S_REDUCE: begin
        // a stays odd here, so a-b of two odd values is even and never underflows.
        if (b_q == '0) begin
          result_d = a_q << k_q;
          state_d  = S_DONE;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = b_q;
          b_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein: a 32-bit and an 8-bit instance, a Euclid
// reference model feeding expected-result queues, and per-instance monitors.
module tb_gcd_stein;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start32, ready32, done32, err32;
  logic [31:0] a32, b32, result32;
  logic [2:0]  dbg32;
  logic        start8, ready8, done8, err8;
  logic [7:0]  a8, b8, result8;
  logic [2:0]  dbg8;

  gcd_stein #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .a_in(a32), .b_in(b32),
    .ready(ready32), .done(done32), .result(result32), .err(err32), .dbg_state(dbg32)
  );

  gcd_stein #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
    .ready(ready8), .done(done8), .result(result8), .err(err8), .dbg_state(dbg8)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp32_q[$];
  logic [8:0]  exp8_q[$];
  logic [32:0] e32;
  logic [8:0]  e8;

  task automatic chk(input string name, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: Euclid's algorithm by remainder; gcd(x,0)=x, gcd(0,0)=0.
  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!reset && done32) begin
      chk("done32_expected", (exp32_q.size() != 0), 1);
      if (exp32_q.size() != 0) begin
        e32 = exp32_q.pop_front();
        chk("result32", result32, e32[31:0]);
        chk("err32", err32, e32[32]);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done8) begin
      chk("done8_expected", (exp8_q.size() != 0), 1);
      if (exp8_q.size() != 0) begin
        e8 = exp8_q.pop_front();
        chk("result8", result8, e8[7:0]);
        chk("err8", err8, e8[8]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit w8, input logic [31:0] a, input logic [31:0] b, input int max_lat);
    int cyc;
    logic [31:0] g;
    cyc = 0;
    while (!(w8 ? ready8 : ready32) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_before_start", (w8 ? ready8 : ready32), 1);
    if (w8) begin
      g = gcd_ref({24'd0, a[7:0]}, {24'd0, b[7:0]});
      a8 = a[7:0];
      b8 = b[7:0];
      start8 = 1'b1;
      exp8_q.push_back({(a[7:0] == 8'd0 && b[7:0] == 8'd0), g[7:0]});
    end else begin
      g = gcd_ref(a, b);
      a32 = a;
      b32 = b;
      start32 = 1'b1;
      exp32_q.push_back({(a == 32'd0 && b == 32'd0), g});
    end
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
    chk("busy_after_accept", (w8 ? ready8 : ready32), 0);
    cyc = 1;
    while (!(w8 ? done8 : done32) && cyc < max_lat + 4) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", (w8 ? done8 : done32), 1);
    chk("latency_within_bound", (cyc <= max_lat), 1);
    @(negedge clk);
    chk("done_one_cycle", (w8 ? done8 : done32), 0);
    chk("ready_after_done", (w8 ? ready8 : ready32), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready32", ready32, 1);
    chk("rst_done32", done32, 0);
    chk("rst_result32", result32, 0);
    chk("rst_err32", err32, 0);
    chk("rst_ready8", ready8, 1);
    chk("rst_result8", result8, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed 32-bit cases
    issue(1'b0, 32'd48, 32'd36, 132);
    issue(1'b0, 32'd17, 32'd13, 132);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 132);
    issue(1'b0, 32'd0, 32'd25, 1);
    issue(1'b0, 32'd0, 32'd0, 1);
    issue(1'b0, 32'd40, 32'd0, 1);
    issue(1'b0, 32'h8000_0000, 32'h4000_0000, 132);

    // start held high and operands toggled while busy
    start32 = 1'b1;
    a32 = 32'd12;
    b32 = 32'd18;
    exp32_q.push_back({1'b0, 32'd6});
    @(negedge clk);
    cyc = 0;
    while (!done32 && cyc < 200) begin
      a32 = $urandom;
      b32 = $urandom;
      @(negedge clk);
      cyc++;
    end
    start32 = 1'b0;
    chk("hold_done_seen", done32, 1);
    @(negedge clk);
    chk("hold_no_second_done_a", done32, 0);
    @(negedge clk);
    chk("hold_no_second_done_b", done32, 0);

    // Reset mid-computation abandons the job
    start32 = 1'b1;
    a32 = 32'd1024;
    b32 = 32'd768;
    @(negedge clk);
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    chk("result_held_busy", result32, 6);
    reset = 1'b1;
    #1;
    chk("midrst_ready", ready32, 1);
    chk("midrst_done", done32, 0);
    chk("midrst_result", result32, 0);
    chk("midrst_err", err32, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'd1024, 32'd768, 132);

    // Random 32-bit pairs, some sharing powers of two, occasional zeros
    for (int i = 0; i < 20; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom << $urandom_range(0, 5));
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom << $urandom_range(0, 5));
      issue(1'b0, ra, rb, ((ra == 0) || (rb == 0)) ? 1 : 132);
    end

    // 8-bit instance
    issue(1'b1, 32'd255, 32'd85, 36);
    issue(1'b1, 32'd128, 32'd64, 36);
    issue(1'b1, 32'd0, 32'd0, 1);
    for (int i = 0; i < 30; i++) begin
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      issue(1'b1, ra, rb, ((ra == 0) || (rb == 0)) ? 1 : 36);
    end

    repeat (2) @(negedge clk);
    chk("queues_drained", exp32_q.size() + exp8_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
